axis_rr_arbiter: RTL

Round-robin arbiter that shares one AXI-Stream master output among NUM_REQ stream requesters, each of which presents packets with valid/data/last. A grant is locked to one requester from its first beat until its tlast beat is accepted, so packets are never interleaved. The output is fully registered, and a status pulse marks each completed packet on the output side. The block sits between several single-word AXIS sources and the shared downstream AXIS slave.

---
 rtl/axis_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: N single-word requesters share one registered master port.
// A grant stays locked from a packet's first beat until its tlast beat is accepted.
module axis_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic [NUM_REQ-1:0]            req_en,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]            s_tlast,
    output logic [NUM_REQ-1:0]            s_tready,
    output logic                          m_tvalid,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tlast,
    output logic [ID_W-1:0]               m_tid,
    input  logic                          m_tready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          pkt_done
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                state, state_next;
    logic [ID_W-1:0]       grant_next;
    logic [ID_W-1:0]       last_grant, last_next;
    logic [ID_W-1:0]       pick;
    logic                  any_eligible;
    logic [NUM_REQ-1:0]    eligible;
    logic                  src_valid;
    logic                  src_last;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  src_hs;

    // Rotating-priority search starting just above the previous winner.
    always_comb begin
        int idx;
        idx          = 0;
        eligible     = s_tvalid & req_en;
        pick         = '0;
        any_eligible = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any_eligible && eligible[ID_W'(idx)]) begin
                any_eligible = 1'b1;
                pick         = ID_W'(idx);
            end
        end
    end

    always_comb begin
        src_valid = 1'b0;
        src_last  = 1'b0;
        src_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                src_valid = s_tvalid[i];
                src_last  = s_tlast[i];
                src_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign src_ready = (state == LOCK) && (!m_tvalid || m_tready);
    assign src_hs    = src_ready && src_valid;
    assign busy      = (state == LOCK);

    always_comb begin
        s_tready           = '0;
        s_tready[grant_id] = src_ready;
    end

    always_comb begin
        state_next = state;
        grant_next = grant_id;
        last_next  = last_grant;
        case (state)
            IDLE: begin
                if (any_eligible) begin
                    state_next = LOCK;
                    grant_next = pick;
                    last_next  = pick;
                end
            end
            LOCK: begin
                if (src_hs && src_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state      <= state_next;
            grant_id   <= grant_next;
            last_grant <= last_next;
        end
    end

    // Output register: a new beat may load in the same cycle the old one drains.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= m_tvalid && m_tready && m_tlast;
            if (src_hs) begin
                m_tvalid <= 1'b1;
                m_tdata  <= src_data;
                m_tlast  <= src_last;
                m_tid    <= grant_id;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule
